// File: rtl/coin_dispenser_pkg.sv
// coin_dispenser_pkg: coin codes and payout state encoding shared with the vending FSM
package coin_dispenser_pkg;
   typedef enum logic [1:0] {EMPTY = 2'b00, NICKEL = 2'b01, DIME = 2'b11} coin_t;
   typedef enum logic [1:0] {IDLE, COIN, GAP, DONE} state_t;
endpackage

// File: rtl/coin_dispenser.sv
// coin_dispenser: greedy dime/nickel payout, one registered coin code per cycle
// COIN_GAP_EN inserts one EMPTY cycle between consecutive coins
module coin_dispenser
   import coin_dispenser_pkg::*;
(
   input  logic       clock,
   input  logic       clear,
   input  logic       start,
   input  logic [3:0] amount,
   output logic       c1,
   output logic       c0,
   output logic       busy,
   output logic       done,
   output logic [3:0] coins_sent
);
`ifdef COIN_GAP_EN
   localparam state_t AFTER_COIN = GAP;
`else
   localparam state_t AFTER_COIN = COIN;
`endif
   state_t     state, state_nx;
   coin_t      coin, coin_nx;
   logic [3:0] remaining, remaining_nx, sent_nx;
   logic       busy_nx, done_nx, dime;
   assign dime = remaining >= 4'd2;
   assign {c1, c0} = coin;
   always_ff @(posedge clock)
      if (clear) begin
         state      <= IDLE;
         remaining  <= '0;
         coin       <= EMPTY;
         busy       <= 1'b0;
         done       <= 1'b0;
         coins_sent <= '0;
      end else begin
         state      <= state_nx;
         remaining  <= remaining_nx;
         coin       <= coin_nx;
         busy       <= busy_nx;
         done       <= done_nx;
         coins_sent <= sent_nx;
      end
   always_comb begin
      state_nx     = state;
      remaining_nx = remaining;
      case (state)
         IDLE: if (start) begin
            remaining_nx = amount;
            state_nx     = amount == 4'd0 ? DONE : COIN;
         end
         COIN: begin
            remaining_nx = remaining - (dime ? 4'd2 : 4'd1);
            state_nx     = remaining_nx == 4'd0 ? DONE : AFTER_COIN;
         end
         GAP:  state_nx = COIN;
         DONE: state_nx = IDLE;
      endcase
   end
   // outputs are computed from the current state and registered, so they lag state by one edge
   always_comb begin
      coin_nx = state == COIN ? (dime ? DIME : NICKEL) : EMPTY;
      busy_nx = state == COIN || state == GAP;
      done_nx = state == DONE;
      sent_nx = state == COIN ? coins_sent + 4'd1 :
                (state == IDLE && start) ? 4'd0 : coins_sent;
   end
endmodule

// File: tb/tb_coin_dispenser.sv
// tb_coin_dispenser: random and directed payouts checked against a queue-based output model
module tb_coin_dispenser;
`ifdef COIN_GAP_EN
   localparam bit GAP_ON = 1'b1;
`else
   localparam bit GAP_ON = 1'b0;
`endif
   typedef struct packed {logic [1:0] c; logic b; logic d; logic [3:0] s;} out_t;
   logic       clock = 1'b0, clear = 1'b1, start = 1'b0;
   logic [3:0] amount = '0;
   logic       c1, c0, busy, done;
   logic [3:0] coins_sent;
   int         vectors = 0, miscompares = 0, cyc = 0;
   out_t       exp_o, q[$];
   logic [3:0] held = '0;
   coin_dispenser dut (
      .clock(clock), .clear(clear), .start(start), .amount(amount),
      .c1(c1), .c0(c0), .busy(busy), .done(done), .coins_sent(coins_sent)
   );
   always #5 clock = ~clock;
   task automatic pin(input string name, input int got, input int req);
      vectors++;
      if (got != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask
   // expected per-cycle outputs of one accepted payout: dimes first, optional gaps, then done
   task automatic plan(input logic [3:0] amt);
      int n;
      n = amt / 2 + amt % 2;
      for (int k = 0; k < n; k++) begin
         q.push_back(out_t'({(k < amt / 2) ? 2'b11 : 2'b01, 1'b1, 1'b0, 4'(k + 1)}));
         if (GAP_ON && k < n - 1) q.push_back(out_t'({2'b00, 1'b1, 1'b0, 4'(k + 1)}));
      end
      q.push_back(out_t'({2'b00, 1'b0, 1'b1, 4'(n)}));
   endtask
   task automatic cycle(input logic st, input logic [3:0] amt, input logic clr);
      out_t got;
      start = st;
      amount = amt;
      clear = clr;
      @(posedge clock);
      cyc++;
      if (clr) begin
         q.delete();
         held = '0;
         exp_o = '0;
      end else if (q.size() > 0) begin
         exp_o = q.pop_front();
         held = exp_o.s;
      end else begin
         if (st) begin
            held = '0;
            plan(amt);
         end
         exp_o = out_t'({2'b00, 1'b0, 1'b0, held});
      end
      @(negedge clock);
      got = {c1, c0, busy, done, coins_sent};
      vectors++;
      if (got !== exp_o) begin
         miscompares++;
         $display("FAIL cycle %0d outputs: got c=%b busy=%b done=%b sent=%0d, required c=%b busy=%b done=%b sent=%0d",
                  cyc, got.c, got.b, got.d, got.s, exp_o.c, exp_o.b, exp_o.d, exp_o.s);
      end
   endtask
   // one payout with random start/amount noise while busy; pins latency and final count
   task automatic txn(input logic [3:0] amt, input int lat_req, input int sent_req);
      int lat;
      lat = 0;
      cycle(1'b1, amt, 1'b0);
      do begin
         cycle(1'($urandom_range(0, 1)), 4'($urandom), 1'b0);
         lat++;
      end while (!done && lat < 40);
      pin($sformatf("latency amount=%0d", amt), lat, lat_req);
      pin($sformatf("coins_sent amount=%0d", amt), coins_sent, sent_req);
   endtask
   initial begin
      cycle(1'b1, 4'd5, 1'b1);
      cycle(1'b0, 4'd0, 1'b1);
      pin("reset outputs", {c1, c0, busy, done, coins_sent}, 0);
      txn(4'd3, GAP_ON ? 4 : 3, 2);
      txn(4'd0, 1, 0);
      txn(4'd15, GAP_ON ? 16 : 9, 8);
      txn(4'd1, 2, 1);
      cycle(1'b0, 4'd0, 1'b0);
      pin("coins_sent held", coins_sent, 1);
      cycle(1'b1, 4'd4, 1'b0);
      cycle(1'b0, 4'd0, 1'b0);
      if (GAP_ON) cycle(1'b0, 4'd0, 1'b0);
      cycle(1'b1, 4'd0, 1'b1);
      pin("abort outputs", {c1, c0, busy, done, coins_sent}, 0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 4'd0, 1'b0);
      txn(4'd2, 2, 1);
      for (int i = 0; i < 600; i++)
         cycle(1'($urandom_range(0, 3) == 0), 4'($urandom), 1'($urandom_range(0, 59) == 0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/coin_dispenser.md
COIN_DISPENSER -- requirements
Module: coin_dispenser

Interface
REQ-001 clock  input  1  sole clock; all state changes on rising edge.
REQ-002 clear  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  request to pay out amount; sampled only in IDLE.
REQ-004 amount  input  4  payout value in nickels (0-15, i.e. 0-75 cents); sampled with start.
REQ-005 c1  output  1  coin code high bit; {c1,c0}: 00 EMPTY, 01 NICKEL, 11 DIME; 10 never driven.
REQ-006 c0  output  1  coin code low bit.
REQ-007 busy  output  1  high while a payout is in progress.
REQ-008 done  output  1  one-cycle pulse marking payout completion.
REQ-009 coins_sent  output  4  coins emitted in current/last payout.

Function
REQ-010 The block SHALL be the transmitting end of the coin-code interface consumed by the vending FSM: one coin code per cycle, EMPTY when idle.
REQ-011 States SHALL be IDLE, COIN, GAP, DONE; all outputs registered.
REQ-012 IDLE: start=1 at edge N SHALL capture amount into a 4-bit remaining register, clear coins_sent, and enter COIN (amount>0) or DONE (amount=0).
REQ-013 COIN: {c1,c0} SHALL be DIME and remaining -= 2 if remaining>=2, else NICKEL and remaining -= 1; coins_sent += 1.
REQ-014 Greedy selection SHALL yield floor(amount/2) dimes then (amount mod 2) nickels, dimes first.
REQ-015 After COIN: remaining=0 -> DONE; remaining>0 -> GAP (macro on) or COIN (macro off).
REQ-016 GAP: {c1,c0}=EMPTY for exactly one cycle, then COIN.
REQ-017 DONE: done=1, busy=0, {c1,c0}=EMPTY for one cycle, then IDLE.
REQ-018 busy SHALL be 1 in COIN and GAP, 0 in IDLE and DONE.
REQ-019 First coin SHALL appear at edge N+1; amount=0 SHALL give done at N+1 with no coin.
REQ-020 start SHALL be ignored in COIN, GAP and DONE; a new request is accepted one cycle after done.
REQ-021 coins_sent SHALL hold its final value until the next accepted start or clear; max 8, no wrap.
REQ-022 Changes on amount while busy SHALL have no effect.

Reset
REQ-023 clear=1 at an edge SHALL force IDLE, c1=c0=0, busy=0, done=0, coins_sent=0, remaining=0, overriding start.
REQ-024 clear mid-payout SHALL abort; no done pulse for the aborted payout; the next coin is not emitted.

Configuration
REQ-025 Macro COIN_GAP_EN: defined -> one EMPTY cycle between consecutive coins (none after last coin); undefined -> coins back-to-back, GAP state unreachable/removed.

Structure
REQ-026 Shared package SHALL hold coin codes (EMPTY, NICKEL, DIME) and state encoding, shared with the vending FSM.
REQ-027 Single module; no sub-module required.

Verification
REQ-028 Macro on, amount=3, start at N -> N+1 DIME, N+2 EMPTY, N+3 NICKEL, N+4 done=1; coins_sent=2.
REQ-029 Macro off, amount=3 -> N+1 DIME, N+2 NICKEL, N+3 done=1, busy high N+1..N+2.
REQ-030 amount=0 -> N+1 done=1, outputs EMPTY, coins_sent=0.
REQ-031 amount=15, macro on -> 7 DIMEs then 1 NICKEL, done at N+16, coins_sent=8; start pulses during payout ignored.
REQ-032 amount=4, clear at second coin cycle -> next cycle all outputs 0, no done, IDLE; fresh start then works.
